// File: rtl/nec_divider_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface nec_divider_seq_if #(
  parameter int WIDTH = 32
);
  localparam int H = WIDTH / 2;

  logic             ce;
  logic             start;
  logic             wide;
  logic             is_signed;
  logic [WIDTH-1:0] num;
  logic [H-1:0]     denom;
  logic             busy;
  logic             done;
  logic [H-1:0]     quot;
  logic [H-1:0]     rem;
  logic             overflow;
  logic             dbz;

  modport master (
    output ce, start, wide, is_signed, num, denom,
    input  busy, done, quot, rem, overflow, dbz
  );

  modport slave (
    input  ce, start, wide, is_signed, num, denom,
    output busy, done, quot, rem, overflow, dbz
  );
endinterface

// File: rtl/nec_divider_seq.sv
// Multi-cycle signed/unsigned restoring divider for DIV/IDIV microcode.
// Wide mode divides WIDTH by H bits, narrow mode H by H/2 bits.
module nec_divider_seq #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input logic              clk,
  input logic              reset_n,
  nec_divider_seq_if.slave bus
);
  localparam int H  = WIDTH / 2;
  localparam int Q4 = H / 2;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] ONE    = 1;
  localparam logic [WIDTH-1:0] W_FULL = ONE << H;
  localparam logic [WIDTH-1:0] W_HALF = ONE << (H - 1);
  localparam logic [WIDTH-1:0] N_FULL = ONE << Q4;
  localparam logic [WIDTH-1:0] N_HALF = ONE << (Q4 - 1);

  typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;
  state_t state, state_n;

  // latched operands; den_r holds the raw divisor until PREP, its magnitude afterwards
  logic             wide_r, sgn_r;
  logic [WIDTH-1:0] num_r;
  logic [H-1:0]     den_r;
  // shift-subtract working set
  logic [WIDTH-1:0] n_sh, q_acc;
  logic [H:0]       r_acc;
  logic [CW-1:0]    cnt;
  logic             sq, sr, dz;
  // registered results
  logic [H-1:0]     quot_q, rem_q;
  logic             ovf_q, dbz_q, done_q;

  // operand magnitude forming (used in PREP)
  logic             sn, sd;
  logic [WIDTH-1:0] num_w, nmag;
  logic [H-1:0]     num_n, den_w, dmag;
  logic [Q4-1:0]    den_n;

  // one DIV step covering BPC quotient bits
  logic [WIDTH-1:0] n_t, q_t;
  logic [H:0]       r_t;

  // sign application and overflow (used in FIX)
  logic [WIDTH-1:0] q_sel, lim;
  logic [H-1:0]     r_sel, quot_n, rem_n;
  logic             ovf_n;

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.quot     = quot_q;
  assign bus.rem      = rem_q;
  assign bus.overflow = ovf_q;
  assign bus.dbz      = dbz_q;

  // Magnitudes of the latched operands; narrow dividend is left-aligned so the
  // same MSB-first shifter serves both modes.
  always_comb begin
    sn    = sgn_r & (wide_r ? num_r[WIDTH-1] : num_r[H-1]);
    sd    = sgn_r & (wide_r ? den_r[H-1]     : den_r[Q4-1]);
    num_w = sn ? -num_r : num_r;
    num_n = sn ? -num_r[H-1:0] : num_r[H-1:0];
    den_w = sd ? -den_r : den_r;
    den_n = sd ? -den_r[Q4-1:0] : den_r[Q4-1:0];
    nmag  = wide_r ? num_w : {num_n, {H{1'b0}}};
    dmag  = wide_r ? den_w : {{Q4{1'b0}}, den_n};
  end

  // Restoring shift-subtract; partial remainder stays below the divisor so H+1 bits suffice.
  always_comb begin
    r_t = r_acc;
    n_t = n_sh;
    q_t = q_acc;
    for (int i = 0; i < BPC; i++) begin
      r_t = {r_t[H-1:0], n_t[WIDTH-1]};
      n_t = {n_t[WIDTH-2:0], 1'b0};
      if (r_t >= {1'b0, den_r}) begin
        r_t = r_t - {1'b0, den_r};
        q_t = {q_t[WIDTH-2:0], 1'b1};
      end else begin
        q_t = {q_t[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Signed results, destination-range check and the divide-by-zero override.
  always_comb begin
    q_sel  = sq ? -q_acc : q_acc;
    r_sel  = sr ? -r_acc[H-1:0] : r_acc[H-1:0];
    quot_n = wide_r ? q_sel[H-1:0] : {{Q4{1'b0}}, q_sel[Q4-1:0]};
    rem_n  = wide_r ? r_sel : {{Q4{1'b0}}, r_sel[Q4-1:0]};
    if (wide_r) lim = sgn_r ? (sq ? W_HALF : W_HALF - ONE) : W_FULL - ONE;
    else        lim = sgn_r ? (sq ? N_HALF : N_HALF - ONE) : N_FULL - ONE;
    ovf_n = (q_acc > lim);
    if (dz) begin
      quot_n = '0;
      rem_n  = '0;
      ovf_n  = 1'b0;
    end
  end

  // State register, frozen while ce is low.
  always_ff @(posedge clk) begin
    if (!reset_n)    state <= IDLE;
    else if (bus.ce) state <= state_n;
  end

  // Next-state: zero divisor skips the DIV phase entirely.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.start) state_n = PREP;
      PREP: state_n = (dmag == '0) ? FIX : DIV;
      DIV:  if (cnt == CW'(1)) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and result registers, advancing only on enabled cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wide_r <= 1'b0; sgn_r <= 1'b0; num_r <= '0; den_r <= '0;
      n_sh   <= '0;   q_acc <= '0;   r_acc <= '0; cnt   <= '0;
      sq     <= 1'b0; sr    <= 1'b0; dz    <= 1'b0;
      quot_q <= '0;   rem_q <= '0;   ovf_q <= 1'b0; dbz_q <= 1'b0; done_q <= 1'b0;
    end else if (bus.ce) begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          wide_r <= bus.wide;
          sgn_r  <= bus.is_signed;
          num_r  <= bus.num;
          den_r  <= bus.denom;
          ovf_q  <= 1'b0;
          dbz_q  <= 1'b0;
        end
        PREP: begin
          n_sh  <= nmag;
          den_r <= dmag;
          r_acc <= '0;
          q_acc <= '0;
          sq    <= sn ^ sd;
          sr    <= sn;
          dz    <= (dmag == '0);
          cnt   <= wide_r ? CW'(WIDTH / BPC) : CW'(H / BPC);
        end
        DIV: begin
          n_sh  <= n_t;
          r_acc <= r_t;
          q_acc <= q_t;
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          quot_q <= quot_n;
          rem_q  <= rem_n;
          ovf_q  <= ovf_n;
          dbz_q  <= dz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nec_divider_seq.sv
// Directed bench for nec_divider_seq (WIDTH=32, BPC=1).
module tb_nec_divider_seq;
  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  nec_divider_seq_if #(.WIDTH(32)) bus ();

  nec_divider_seq #(.WIDTH(32), .BPC(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns in the done cycle, or after the bound with cyc=-1.
  task automatic run_op(input logic w, input logic s, input logic [31:0] n,
                        input logic [15:0] d, output int cyc, output logic busy1);
    bus.start = 1'b1; bus.wide = w; bus.is_signed = s; bus.num = n; bus.denom = d;
    cyc = -1;
    @(negedge clk);
    bus.start = 1'b0;
    busy1 = bus.busy;
    for (int c = 1; c <= 200; c++) begin
      if (bus.done) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int   cyc, extra, seen;
    logic b1;

    reset_n = 1'b0;
    bus.ce = 1'b1; bus.start = 1'b0; bus.wide = 1'b0; bus.is_signed = 1'b0;
    bus.num = '0; bus.denom = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quot", 32'(bus.quot), 32'd0);
    chk("rst_rem",  32'(bus.rem), 32'd0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);
    chk("rst_dbz",  32'(bus.dbz), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: wide unsigned 100000/7
    run_op(1'b1, 1'b0, 32'd100000, 16'd7, cyc, b1);
    chk("t1_busy1", 32'(b1), 32'd1);
    chk("t1_cyc",   32'(cyc), 32'd35);
    chk("t1_busyd", 32'(bus.busy), 32'd0);
    chk("t1_quot",  32'(bus.quot), 32'd14285);
    chk("t1_rem",   32'(bus.rem), 32'd5);
    chk("t1_ovf",   32'(bus.overflow), 32'd0);
    chk("t1_dbz",   32'(bus.dbz), 32'd0);
    @(negedge clk);
    chk("t1_pulse", 32'(bus.done), 32'd0);

    // 2: narrow signed -7/2, upper input bits must be ignored
    run_op(1'b0, 1'b1, 32'hABCD_FFF9, 16'h5502, cyc, b1);
    chk("t2_cyc",  32'(cyc), 32'd19);
    chk("t2_quot", 32'(bus.quot), 32'h0000_00FD);
    chk("t2_rem",  32'(bus.rem), 32'h0000_00FF);
    chk("t2_ovf",  32'(bus.overflow), 32'd0);
    @(negedge clk);

    // 3: signed narrow range boundaries
    run_op(1'b0, 1'b1, 32'h0000_FF80, 16'h0001, cyc, b1);
    chk("t3a_quot", 32'(bus.quot), 32'h0000_0080);
    chk("t3a_rem",  32'(bus.rem), 32'd0);
    chk("t3a_ovf",  32'(bus.overflow), 32'd0);
    @(negedge clk);
    run_op(1'b0, 1'b1, 32'h0000_0080, 16'h0001, cyc, b1);
    chk("t3b_ovf",  32'(bus.overflow), 32'd1);
    chk("t3b_quot", 32'(bus.quot), 32'h0000_0080);
    @(negedge clk);

    // 4: unsigned wide overflow
    run_op(1'b1, 1'b0, 32'h0001_0000, 16'h0001, cyc, b1);
    chk("t4_ovf",  32'(bus.overflow), 32'd1);
    chk("t4_quot", 32'(bus.quot), 32'd0);
    chk("t4_rem",  32'(bus.rem), 32'd0);
    @(negedge clk);

    // 5: divide by zero, wide signed then narrow (low divisor byte zero)
    run_op(1'b1, 1'b1, 32'h1234_5678, 16'h0000, cyc, b1);
    chk("t5a_cyc",  32'(cyc), 32'd3);
    chk("t5a_dbz",  32'(bus.dbz), 32'd1);
    chk("t5a_ovf",  32'(bus.overflow), 32'd0);
    chk("t5a_quot", 32'(bus.quot), 32'd0);
    chk("t5a_rem",  32'(bus.rem), 32'd0);
    @(negedge clk);
    run_op(1'b0, 1'b0, 32'h0000_1234, 16'h0100, cyc, b1);
    chk("t5b_cyc",  32'(cyc), 32'd3);
    chk("t5b_dbz",  32'(bus.dbz), 32'd1);
    @(negedge clk);
    // valid signed wide divide clears dbz: -100000/7
    run_op(1'b1, 1'b1, 32'hFFFE_7960, 16'd7, cyc, b1);
    chk("t5c_cyc",  32'(cyc), 32'd35);
    chk("t5c_dbz",  32'(bus.dbz), 32'd0);
    chk("t5c_quot", 32'(bus.quot), 32'h0000_C833);
    chk("t5c_rem",  32'(bus.rem), 32'h0000_FFFB);
    chk("t5c_ovf",  32'(bus.overflow), 32'd0);
    @(negedge clk);

    // 6: ce toggling, start held until accepted, stray start at cycle 10
    bus.wide = 1'b1; bus.is_signed = 1'b0; bus.num = 32'd100000; bus.denom = 16'd7;
    cyc = -1; extra = 0;
    for (int c = 0; c <= 150; c++) begin
      if (bus.done && cyc < 0) cyc = c;
      else if (bus.done && c > cyc + 1) extra++;
      bus.ce    = (c % 2 == 1);
      bus.start = (c <= 1) || (c == 10);
      @(negedge clk);
    end
    bus.ce = 1'b1; bus.start = 1'b0;
    chk("t6_cyc",   32'(cyc), 32'd70);
    chk("t6_extra", 32'(extra), 32'd0);
    chk("t6_quot",  32'(bus.quot), 32'd14285);
    chk("t6_rem",   32'(bus.rem), 32'd5);
    chk("t6_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);

    // 7: reset at cycle 10 of case 1
    bus.start = 1'b1; bus.wide = 1'b1; bus.is_signed = 1'b0;
    bus.num = 32'd100000; bus.denom = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_done", 32'(bus.done), 32'd0);
    chk("t7_quot", 32'(bus.quot), 32'd0);
    chk("t7_rem",  32'(bus.rem), 32'd0);
    chk("t7_ovf",  32'(bus.overflow), 32'd0);
    chk("t7_dbz",  32'(bus.dbz), 32'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("t7_nodone", 32'(seen), 32'd0);
    run_op(1'b1, 1'b0, 32'd100000, 16'd7, cyc, b1);
    chk("t7r_cyc",  32'(cyc), 32'd35);
    chk("t7r_quot", 32'(bus.quot), 32'd14285);
    chk("t7r_rem",  32'(bus.rem), 32'd5);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
